// File: rtl/carus_clk_gate_ctrl.sv
// Clock-gate control FSM for the Carus domain: wakes the gated clock on demand,
// acks after WAKE_CYCLES, gates off after IDLE_TIMEOUT idle cycles. Optional macro: CARUS_CLK_GATE_CTRL_STATS_EN.
module carus_clk_gate_ctrl #(
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        busy_i,
  input  logic        force_on_i,
  input  logic        stats_clr_i,
  output logic        clk_en_o,
  output logic        ack_o,
  output logic [1:0]  state_o,
  output logic [31:0] gated_cycles_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             ack_q, ack_d;
  logic             wake;
  logic             active;

  assign wake   = req_i | force_on_i;
  assign active = wake | busy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The shared counter holds the remaining wake delay in WAKE and the
  // remaining idle budget in IDLE; it is meaningless in OFF and ON.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (wake) begin
          if (WAKE_CYCLES == 0) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
      end
      ST_WAKE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ON: begin
        if (!active) begin
          if (IDLE_TIMEOUT <= 1) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = IDLE_LOAD;
          end
        end
      end
      ST_IDLE: begin
        // Activity wins over an expiring counter.
        if (active) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clk_en_d = (state_d != ST_OFF);
    ack_d    = (state_d == ST_ON) || (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
    end
  end

  assign clk_en_o = clk_en_q;
  assign ack_o    = ack_q;
  assign state_o  = state_q;

`ifdef CARUS_CLK_GATE_CTRL_STATS_EN
  logic [31:0] gated_q;

  // Counts cycles with the registered enable low, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      gated_q <= '0;
    end else if (!clk_en_q && (gated_q != 32'hFFFF_FFFF)) begin
      gated_q <= gated_q + 32'd1;
    end
  end

  assign gated_cycles_o = gated_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr_i;
  assign gated_cycles_o   = '0;
`endif

endmodule

// File: tb/tb_carus_clk_gate_ctrl.sv
// Directed bench for carus_clk_gate_ctrl: default instance plus a WAKE=0/IDLE=1 instance.
module tb_carus_clk_gate_ctrl;

`ifdef CARUS_CLK_GATE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, busy_i, force_on_i, stats_clr_i;
  logic        clk_en_o, ack_o;
  logic [1:0]  state_o;
  logic [31:0] gated_cycles_o;

  logic        req_b, busy_b, force_b, clr_b;
  logic        clk_en_b, ack_b;
  logic [1:0]  state_b;
  logic [31:0] gated_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  carus_clk_gate_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .busy_i         (busy_i),
    .force_on_i     (force_on_i),
    .stats_clr_i    (stats_clr_i),
    .clk_en_o       (clk_en_o),
    .ack_o          (ack_o),
    .state_o        (state_o),
    .gated_cycles_o (gated_cycles_o)
  );

  carus_clk_gate_ctrl #(.WAKE_CYCLES(0), .IDLE_TIMEOUT(1), .CNT_W(8)) dut_b (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_b),
    .busy_i         (busy_b),
    .force_on_i     (force_b),
    .stats_clr_i    (clr_b),
    .clk_en_o       (clk_en_b),
    .ack_o          (ack_b),
    .state_o        (state_b),
    .gated_cycles_o (gated_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive the default instance's inputs, let one edge sample them, settle past it.
  task automatic applyStimulus(input logic req, input logic busy, input logic force_on, input logic clr);
    req_i       = req;
    busy_i      = busy;
    force_on_i  = force_on;
    stats_clr_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkA(input string tag, input logic en, input logic ack, input logic [1:0] st);
    checkOutput({tag, ".en"},    32'(clk_en_o), 32'(en));
    checkOutput({tag, ".ack"},   32'(ack_o),    32'(ack));
    checkOutput({tag, ".state"}, 32'(state_o),  32'(st));
  endtask

  task automatic checkB(input string tag, input logic en, input logic ack, input logic [1:0] st);
    checkOutput({tag, ".en"},    32'(clk_en_b), 32'(en));
    checkOutput({tag, ".ack"},   32'(ack_b),    32'(ack));
    checkOutput({tag, ".state"}, 32'(state_b),  32'(st));
  endtask

  // Three wake samples: WAKE, WAKE, then ON with ack.
  task automatic wakeToOn(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkA({tag, ".wake0"}, 1'b1, 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkA({tag, ".wake1"}, 1'b1, 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkA({tag, ".on"}, 1'b1, 1'b1, 2'd2);
  endtask

  // Eight idle samples from ON: seven in IDLE, OFF on the eighth.
  task automatic runIdle(input string tag);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (k < 7) checkA({tag, ".idle"}, 1'b1, 1'b1, 2'd3);
      else       checkA({tag, ".off"},  1'b0, 1'b0, 2'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = 1'b0; busy_i = 1'b0; force_on_i = 1'b0; stats_clr_i = 1'b0;
    req_b = 1'b0; busy_b = 1'b0; force_b = 1'b0; clr_b = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkA("reset", 1'b0, 1'b0, 2'd0);
    checkOutput("reset.gated", gated_cycles_o, 32'd0);
    checkB("reset_b", 1'b0, 1'b0, 2'd0);

    // 50 OFF cycles on the default instance while the fast instance is pulsed.
    rst_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      req_b = (i == 20) || (i >= 30 && i <= 32);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 10) checkA("off_hold", 1'b0, 1'b0, 2'd0);
      if (i == 20 || (i >= 30 && i <= 32)) checkB("b_on", 1'b1, 1'b1, 2'd2);
      if (i == 21 || i == 33) checkB("b_off", 1'b0, 1'b0, 2'd0);
    end
    req_b = 1'b0;
    checkOutput("stats_50", gated_cycles_o, STATS ? 32'd50 : 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stats_clr", gated_cycles_o, 32'd0);
    checkA("clr_off", 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stats_after_clr", gated_cycles_o, STATS ? 32'd1 : 32'd0);

    wakeToOn("w1");
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkA("on_hold", 1'b1, 1'b1, 2'd2);
    end
    runIdle("timeout");

    // Wake sampled on the first OFF cycle, then a busy pulse restarts the timeout.
    wakeToOn("rewake");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkA("pre_busy.idle", 1'b1, 1'b1, 2'd3);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkA("busy_pulse", 1'b1, 1'b1, 2'd2);
    runIdle("after_busy");

    // Activity on the very cycle the counter would expire keeps the clock on.
    wakeToOn("w3");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkA("pre_expire.idle", 1'b1, 1'b1, 2'd3);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkA("expire_active", 1'b1, 1'b1, 2'd2);
    runIdle("after_expire");

    // A request withdrawn during WAKE still reaches ON then times out.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkA("withdraw.wake0", 1'b1, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkA("withdraw.wake1", 1'b1, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkA("withdraw.on", 1'b1, 1'b1, 2'd2);
    runIdle("withdraw");

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkA("force", 1'b1, (i >= 2), (i >= 2) ? 2'd2 : 2'd1);
    end
    runIdle("force_release");

    wakeToOn("w5");
    rst_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkA("rst_on", 1'b0, 1'b0, 2'd0);
    checkOutput("rst_on.gated", gated_cycles_o, 32'd0);
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkA("post_rst", 1'b0, 1'b0, 2'd0);
    checkOutput("post_rst.gated", gated_cycles_o, STATS ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
